// File: rtl/snax_shell_csr_launcher_pkg.sv
// snax_shell_pkg: shared types and constants for SNAX shell launch logic
package snax_shell_pkg;
  typedef enum logic {IDLE, BUSY} launch_state_e;
  localparam int RoPerfIdx   = 0;
  localparam int RoBusyIdx   = 1;
  localparam int RoLaunchIdx = 2;
  localparam int MaxNumCtrl  = 8;
endpackage

// File: rtl/snax_shell_csr_launcher_if.sv
// snax_shell_csr_launcher_if: per-sub-controller config handshake bundle
interface snax_shell_csr_launcher_if #(
  parameter int NumCtrl  = 2,
  parameter int CfgWidth = 320
);
  logic [NumCtrl-1:0]  valid;
  logic [NumCtrl-1:0]  ready;
  logic [NumCtrl-1:0]  busy;
  logic [CfgWidth-1:0] cfg;
  modport master (output valid, cfg, input ready, busy);
  modport slave  (input valid, cfg, output ready, busy);
endinterface

// File: rtl/snax_shell_csr_launcher_perf_counter.sv
// snax_shell_perf_counter: saturating counter with synchronous clear and enable
module snax_shell_perf_counter #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);
  logic [Width-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : (en_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/snax_shell_csr_launcher.sv
// snax_shell_csr_launcher: per-controller CSR launch join with busy tracking and perf counter.
// Define SNAX_SHELL_LAUNCH_CNT_EN to expose an accepted-launch counter on RO CSR 2.
module snax_shell_csr_launcher
  import snax_shell_pkg::*;
#(
  parameter int NumCtrl      = 2,
  parameter int RegRWCount   = 10,
  parameter int RegROCount   = 2,
  parameter int RegDataWidth = 32,
  parameter int EnableIdx    = RegRWCount - 1,
  parameter int CounterWidth = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i,
  input  logic                               csr_reg_set_valid_i,
  output logic                               csr_reg_set_ready_o,
  output logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o,
  snax_shell_csr_launcher_if.master          ctrl
);
  logic [NumCtrl-1:0] en, done_q, done_d, fire;
  logic accept, grace_q, busy;
  launch_state_e state_q;
  logic [CounterWidth-1:0] perf;
  logic [RegDataWidth-1:0] launch_cnt;
  assign en = csr_reg_set_i[EnableIdx*RegDataWidth +: NumCtrl];
  assign ctrl.valid = {NumCtrl{csr_reg_set_valid_i}} & en & ~done_q;
  assign ctrl.cfg = csr_reg_set_i;
  assign fire = ctrl.valid & ctrl.ready;
  assign csr_reg_set_ready_o = csr_reg_set_valid_i & (&(~en | done_q | fire));
  assign accept = csr_reg_set_ready_o;
  assign done_d = accept ? '0 : done_q | fire;
  assign busy = (state_q == BUSY) | (|ctrl.busy);
  // grace_q blocks the BUSY exit in the cycle right after acceptance
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      grace_q <= 1'b0;
      done_q  <= '0;
    end else begin
      done_q  <= done_d;
      grace_q <= accept;
      if (accept) state_q <= BUSY;
      else if (state_q == BUSY && !grace_q && !(|ctrl.busy) && !csr_reg_set_valid_i) state_q <= IDLE;
    end
  snax_shell_perf_counter #(.Width(CounterWidth)) i_perf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (accept),
    .en_i   (state_q == BUSY),
    .cnt_o  (perf)
  );
`ifdef SNAX_SHELL_LAUNCH_CNT_EN
  logic [RegDataWidth-1:0] launch_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) launch_cnt_q <= '0;
    else if (accept) launch_cnt_q <= launch_cnt_q + 1'b1;
  assign launch_cnt = launch_cnt_q;
`else
  assign launch_cnt = '0;
`endif
  for (genvar r = 0; r < RegROCount; r++) begin : g_ro
    assign csr_reg_ro_set_o[r*RegDataWidth +: RegDataWidth] =
      r == RoPerfIdx   ? RegDataWidth'(perf) :
      r == RoBusyIdx   ? RegDataWidth'(busy) :
      r == RoLaunchIdx ? launch_cnt : '0;
  end
endmodule

// File: tb/tb_snax_shell_csr_launcher.sv
// tb_snax_shell_csr_launcher: directed self-checking bench for the CSR launcher
module tb_snax_shell_csr_launcher;
`ifdef SNAX_SHELL_LAUNCH_CNT_EN
  localparam int RO = 3;
`else
  localparam int RO = 2;
`endif
  localparam int W = 32;
  localparam int RW = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [RW*W-1:0] csr;
  logic vld;
  logic rdy;
  logic [RO*W-1:0] ro;
  int n_cmp = 0;
  int n_err = 0;
  int nf[2] = '{0, 0};
  int b0, b1;
  snax_shell_csr_launcher_if #(.NumCtrl(2), .CfgWidth(RW*W)) ifc ();
  snax_shell_csr_launcher #(
    .NumCtrl(2), .RegRWCount(RW), .RegROCount(RO), .RegDataWidth(W),
    .EnableIdx(RW-1), .CounterWidth(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .csr_reg_set_i(csr), .csr_reg_set_valid_i(vld),
    .csr_reg_set_ready_o(rdy), .csr_reg_ro_set_o(ro), .ctrl(ifc.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    for (int i = 0; i < 2; i++) if (ifc.valid[i] && ifc.ready[i]) nf[i]++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_en(input logic [1:0] m);
    for (int k = 0; k < RW; k++) csr[k*W +: W] = 32'hA5000000 + k;
    csr[(RW-1)*W +: W] = {30'h0, m};
  endtask
  initial begin
    vld = 1'b0;
    ifc.ready = 2'b00;
    ifc.busy = 2'b00;
    set_en(2'b11);
    #2;
    chk("rst_ready", 64'(rdy), 64'd0);
    chk("rst_valid", 64'(ifc.valid), 64'd0);
    chk("rst_ro", 64'(ro), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // T1: both ready on the first valid cycle
    vld = 1'b1; ifc.ready = 2'b11; #1;
    chk("t1_valid", 64'(ifc.valid), 64'd3);
    chk("t1_ready", 64'(rdy), 64'd1);
    chk("t1_cfg", 64'(ifc.cfg[63:0]), 64'hA5000001A5000000);
    tick();
    vld = 1'b0; ifc.ready = 2'b00; #1;
    chk("t1_busy", 64'(ro[63:32]), 64'd1);
    chk("t1_perf0", 64'(ro[31:0]), 64'd0);
    tick(); tick();
    chk("t1_idle", 64'(ro[63:32]), 64'd0);
    chk("t1_perf", 64'(ro[31:0]), 64'd2);
    tick();
    chk("t1_frozen", 64'(ro[31:0]), 64'd2);
    // T2: staggered readies
    b0 = nf[0]; b1 = nf[1];
    vld = 1'b1; ifc.ready = 2'b01; #1;
    chk("t2_c0_valid", 64'(ifc.valid), 64'd3);
    chk("t2_c0_ready", 64'(rdy), 64'd0);
    tick();
    ifc.ready = 2'b00; #1;
    chk("t2_c1_valid", 64'(ifc.valid), 64'd2);
    chk("t2_c1_ready", 64'(rdy), 64'd0);
    tick();
    ifc.ready = 2'b01; #1;
    chk("t2_c2_valid", 64'(ifc.valid), 64'd2);
    chk("t2_c2_ready", 64'(rdy), 64'd0);
    tick();
    ifc.ready = 2'b10; #1;
    chk("t2_c3_ready", 64'(rdy), 64'd1);
    tick();
    vld = 1'b0; ifc.ready = 2'b00; #1;
    chk("t2_valid_off", 64'(ifc.valid), 64'd0);
    chk("t2_fire0", 64'(nf[0] - b0), 64'd1);
    chk("t2_fire1", 64'(nf[1] - b1), 64'd1);
    tick(); tick();
    // T3: controller 1 bypassed
    set_en(2'b01);
    vld = 1'b1; ifc.ready = 2'b11; #1;
    chk("t3_valid", 64'(ifc.valid), 64'd1);
    chk("t3_ready", 64'(rdy), 64'd1);
    tick();
    vld = 1'b0; ifc.ready = 2'b00;
    tick(); tick(); tick();
    chk("t3_perf", 64'(ro[31:0]), 64'd2);
    // T4: nothing enabled
    set_en(2'b00);
    vld = 1'b1; #1;
    chk("t4_ready", 64'(rdy), 64'd1);
    chk("t4_valid", 64'(ifc.valid), 64'd0);
    tick();
    vld = 1'b0; #1;
    chk("t4_perf_clr", 64'(ro[31:0]), 64'd0);
`ifdef SNAX_SHELL_LAUNCH_CNT_EN
    chk("t4_launch_cnt", 64'(ro[95:64]), 64'd4);
`endif
    tick(); tick();
    // T5: sub-controller busy for 10 cycles after accept
    set_en(2'b11);
    vld = 1'b1; ifc.ready = 2'b11;
    tick();
    vld = 1'b0; ifc.ready = 2'b00;
    for (int c = 0; c < 10; c++) begin
      ifc.busy = 2'b01; #1;
      chk($sformatf("t5_busy%0d", c), 64'(ro[63:32]), 64'd1);
      tick();
    end
    ifc.busy = 2'b00; #1;
    chk("t5_tail_busy", 64'(ro[63:32]), 64'd1);
    tick();
    chk("t5_idle", 64'(ro[63:32]), 64'd0);
    chk("t5_perf", 64'(ro[31:0]), 64'd11);
    tick();
    chk("t5_frozen", 64'(ro[31:0]), 64'd11);
    // T6: reset after ctrl 0 fired, before ctrl 1
    vld = 1'b1; ifc.ready = 2'b01;
    tick();
    ifc.ready = 2'b00; #1;
    chk("t6_pre_valid", 64'(ifc.valid), 64'd2);
    rst_n = 1'b0; #1;
    chk("t6_rst_valid", 64'(ifc.valid), 64'd3);
    chk("t6_rst_ro", 64'(ro), 64'd0);
    rst_n = 1'b1; ifc.ready = 2'b11; #1;
    chk("t6_reoffer", 64'(ifc.valid), 64'd3);
    chk("t6_ready", 64'(rdy), 64'd1);
    tick();
    vld = 1'b0; ifc.ready = 2'b00;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
